// File: rtl/ram.sv
// Word-organised data RAM: byte address in, sync write, async read.
// Ports: wr_data/rd_data data, rdEn/wrEn enables, addr byte address, clk, rst_n.
module ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 256
) (
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  input  logic             rdEn,
  input  logic             wrEn,
  input  logic [WIDTH-1:0] addr,
  input  logic             clk,
  input  logic             rst_n
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    idx;
  logic             unused_addr;

  // Byte lanes and upper bits drop out, so
  // high addresses alias onto the array.
  assign idx = addr[AW+1:2];
  assign unused_addr = ^{addr[WIDTH-1:AW+2], addr[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wrEn) begin
      mem[idx] <= wr_data;
    end
  end

  // rst_n gates the read so the output
  // drops the instant reset asserts.
  always_comb begin
    rd_data = '0;
    if (rdEn && rst_n) begin
      rd_data = mem[idx];
    end
  end

endmodule

// File: tb/tb_ram.sv
// Directed self-checking bench for ram.
// Drives on falling edges, checks after the write edge.
module tb_ram;

  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        rdEn;
  logic        wrEn;
  logic [31:0] addr;
  logic        clk;
  logic        rst_n;

  int checks = 0;
  int errors = 0;

  logic [31:0] model [256];

  ram #(.WIDTH(32), .DEPTH(256)) dut (
    .wr_data(wr_data),
    .rd_data(rd_data),
    .rdEn(rdEn),
    .wrEn(wrEn),
    .addr(addr),
    .clk(clk),
    .rst_n(rst_n)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) & 32'd255);
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [31:0] a,
                          input logic [31:0] d);
    @(negedge clk);
    addr = a;
    wr_data = d;
    wrEn = 1'b1;
    rdEn = 1'b0;
    @(negedge clk);
    wrEn = 1'b0;
    model[widx(a)] = d;
  endtask

  task automatic do_read(input string tag,
                         input logic [31:0] a,
                         input logic [31:0] e);
    addr = a;
    rdEn = 1'b1;
    #1;
    check(tag, rd_data, e);
  endtask

  initial begin
    logic [31:0] d;
    wr_data = '0;
    rdEn = 1'b0;
    wrEn = 1'b0;
    addr = '0;
    rst_n = 1'b0;
    for (int i = 0; i < 256; i++) model[i] = '0;

    // reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    do_read("rst_hold_0x000", 32'h000, 32'h0);
    rst_n = 1'b1;
    #1;
    do_read("rst_0x000", 32'h000, 32'h0);
    do_read("rst_0x3fc", 32'h3FC, 32'h0);

    // sweep 1 and 2
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 256; i++) begin
        d = $urandom;
        do_write(32'(i * 4), d);
        do_read(pass == 0 ? "sweep1" : "sweep2",
                32'(i * 4), d);
      end
    end
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      do_read("sweep_final", 32'(i * 4), model[i]);
    end

    // alignment / alias
    do_write(32'h010, 32'hDEADBEEF);
    do_read("align_0x011", 32'h011, 32'hDEADBEEF);
    do_read("align_0x013", 32'h013, 32'hDEADBEEF);
    do_write(32'h404, 32'h12345678);
    do_read("alias_0x004", 32'h004, 32'h12345678);

    // enables
    addr = 32'h010;
    rdEn = 1'b0;
    #1;
    check("rden_off", rd_data, 32'h0);
    @(negedge clk);
    addr = 32'h010;
    wr_data = 32'hFFFFFFFF;
    wrEn = 1'b0;
    @(negedge clk);
    do_read("wren_off", 32'h010, 32'hDEADBEEF);

    do_write(32'h020, 32'hA5A5A5A5);
    addr = 32'h020;
    rdEn = 1'b1;
    wrEn = 1'b1;
    wr_data = 32'h5A5A5A5A;
    #1;
    check("rw_before", rd_data, 32'hA5A5A5A5);
    @(posedge clk);
    #1;
    check("rw_after", rd_data, 32'h5A5A5A5A);
    @(negedge clk);
    wrEn = 1'b0;

    // reset mid-run
    do_write(32'h000, 32'h11111111);
    do_write(32'h004, 32'h22222222);
    do_write(32'h008, 32'h33333333);
    do_write(32'h00C, 32'h44444444);
    do_read("pre_rst_0x00c", 32'h00C, 32'h44444444);
    addr = 32'h000;
    wr_data = 32'hCAFEF00D;
    wrEn = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async", rd_data, 32'h0);
    @(posedge clk);
    #3;
    wrEn = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    do_read("post_rst_0x000", 32'h000, 32'h0);
    do_read("post_rst_0x004", 32'h004, 32'h0);
    do_read("post_rst_0x008", 32'h008, 32'h0);
    do_read("post_rst_0x00c", 32'h00C, 32'h0);
    do_read("post_rst_0x020", 32'h020, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
